inst_issue_seq: RTL and testbench

// - Single-issue sequencer between the instruction source and the execute units.
// - Accepts one 32-bit instruction on a valid/ready handshake and classifies it.
// - Holds the instruction for the class-specific number of cycles.
// - Drives the memory handshake, branch flush and undefined-instruction trap, then retires.

---
 rtl/inst_seq_pkg.sv | 31 +++
 rtl/inst_classify.sv | 33 +++
 rtl/inst_issue_seq.sv | 166 ++++++++++++++++
 tb/tb_inst_issue_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/inst_seq_pkg.sv
// Shared codes for the instruction issue sequencer: instruction classes, data
// sub-types and sequencer state encoding.
package inst_seq_pkg;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_DATA  = 2'd1,
        CLS_LDST  = 2'd2,
        CLS_BR    = 2'd3
    } cls_e;

    typedef enum logic [2:0] {
        DT_NONE  = 3'd0,
        DT_IMM   = 3'd1,
        DT_SHIMM = 3'd2,
        DT_SHREG = 3'd3,
        DT_MUL   = 3'd4
    } dtype_e;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMemWait,
        StFlush,
        StTrap
    } state_e;

    // Width of the per-instruction execute/flush cycle down-counter.
    localparam int unsigned CycW = 16;

endpackage

// File: rtl/inst_classify.sv
// Combinational instruction decoder: class from bits [27:26], data sub-type with
// first-match priority (immediate, shift-imm, shift-reg, multiply).
module inst_classify
    import inst_seq_pkg::*;
(
    input  logic [31:0] inst_i,
    output cls_e        type_o,
    output dtype_e      dtype_o
);

    always_comb begin
        type_o  = CLS_OTHER;
        dtype_o = DT_NONE;
        unique case (inst_i[27:26])
            2'b00: begin
                type_o = CLS_DATA;
                if (inst_i[25]) begin
                    dtype_o = DT_IMM;
                end else if (!inst_i[4]) begin
                    dtype_o = DT_SHIMM;
                end else if (!inst_i[7]) begin
                    dtype_o = DT_SHREG;
                end else if (!inst_i[24] && (inst_i[7:4] == 4'b1001)) begin
                    dtype_o = DT_MUL;
                end
            end
            2'b01:   type_o = CLS_LDST;
            2'b10:   type_o = CLS_BR;
            default: type_o = CLS_OTHER;
        endcase
    end

endmodule

// File: rtl/inst_issue_seq.sv
// Single-issue sequencer: accepts, classifies, holds and retires one instruction.
// Optional INST_SEQ_PERF_EN adds mul_cnt_o and mem_stall_cnt_o performance counters.
module inst_issue_seq
    import inst_seq_pkg::*;
#(
    parameter int unsigned MUL_CYCLES   = 3,
    parameter int unsigned SHREG_CYCLES = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inst_valid_i,
    input  logic [31:0]      inst_in_i,
    output logic             inst_ready_o,
    output logic             exec_valid_o,
    output logic [31:0]      exec_inst_o,
    output logic [1:0]       exec_type_o,
    output logic [2:0]       exec_dtype_o,
    output logic             mem_req_o,
    input  logic             mem_ack_i,
    output logic             flush_o,
    output logic             retire_o,
    output logic             undef_trap_o,
    output logic             busy_o,
`ifdef INST_SEQ_PERF_EN
    output logic [CNT_W-1:0] mul_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
`endif
    output logic [CNT_W-1:0] retire_cnt_o
);

    state_e            state_q, state_d;
    logic [31:0]       inst_q, inst_d;
    cls_e              cls_q, cls_d, cls_c;
    dtype_e            dt_q, dt_d, dt_c;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic              retire, trap, mem_req, flush;

    inst_classify u_classify (
        .inst_i  (inst_in_i),
        .type_o  (cls_c),
        .dtype_o (dt_c)
    );

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        cls_d   = cls_q;
        dt_d    = dt_q;
        cyc_d   = cyc_q;
        retire  = 1'b0;
        trap    = 1'b0;
        mem_req = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inst_valid_i) begin
                    inst_d = inst_in_i;
                    cls_d  = cls_c;
                    dt_d   = dt_c;
                    cyc_d  = '0;
                    unique case (cls_c)
                        CLS_DATA: begin
                            unique case (dt_c)
                                DT_IMM, DT_SHIMM: state_d = StExec;
                                DT_SHREG: begin
                                    state_d = StExec;
                                    cyc_d   = CycW'(SHREG_CYCLES - 1);
                                end
                                DT_MUL: begin
                                    state_d = StExec;
                                    cyc_d   = CycW'(MUL_CYCLES - 1);
                                end
                                default: state_d = StTrap;
                            endcase
                        end
                        CLS_LDST: state_d = StMemWait;
                        CLS_BR: begin
                            state_d = StFlush;
                            cyc_d   = CycW'(FLUSH_CYCLES - 1);
                        end
                        default: state_d = StTrap;
                    endcase
                end
            end
            StExec, StFlush: begin
                flush = (state_q == StFlush);
                if (cyc_q == '0) begin
                    retire  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            StMemWait: begin
                mem_req = 1'b1;
                if (mem_ack_i) begin
                    retire  = 1'b1;
                    state_d = StIdle;
                end
            end
            StTrap: begin
                trap    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign retire_cnt_d = retire ? retire_cnt_q + 1'b1 : retire_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            inst_q       <= '0;
            cls_q        <= CLS_OTHER;
            dt_q         <= DT_NONE;
            cyc_q        <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            cls_q        <= cls_d;
            dt_q         <= dt_d;
            cyc_q        <= cyc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Latched fields are masked in IDLE so they read as zero between instructions.
    assign busy_o       = (state_q != StIdle);
    assign inst_ready_o = ~busy_o;
    assign exec_valid_o = busy_o;
    assign exec_inst_o  = busy_o ? inst_q : '0;
    assign exec_type_o  = busy_o ? cls_q : CLS_OTHER;
    assign exec_dtype_o = busy_o ? dt_q : DT_NONE;
    assign mem_req_o    = mem_req;
    assign flush_o      = flush;
    assign retire_o     = retire;
    assign undef_trap_o = trap;
    assign retire_cnt_o = retire_cnt_q;

`ifdef INST_SEQ_PERF_EN
    logic [CNT_W-1:0] mul_cnt_q, mem_stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mul_cnt_q       <= '0;
            mem_stall_cnt_q <= '0;
        end else begin
            if (retire && (cls_q == CLS_DATA) && (dt_q == DT_MUL)) begin
                mul_cnt_q <= mul_cnt_q + 1'b1;
            end
            if (mem_req && !mem_ack_i) begin
                mem_stall_cnt_q <= mem_stall_cnt_q + 1'b1;
            end
        end
    end

    assign mul_cnt_o       = mul_cnt_q;
    assign mem_stall_cnt_o = mem_stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_issue_seq.sv
// Self-checking bench for inst_issue_seq: directed and random instructions checked
// cycle by cycle against a latency/class reference model; a CNT_W=4 twin checks wrap.
module tb_inst_issue_seq;

    localparam int unsigned MUL_C = 3;
    localparam int unsigned SHR_C = 2;
    localparam int unsigned FL_C  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] inst_in = '0;

    logic        inst_ready, exec_valid, mem_req, flush, retire, undef_trap, busy;
    logic [31:0] exec_inst;
    logic [1:0]  exec_type;
    logic [2:0]  exec_dtype;
    logic [15:0] retire_cnt;

    logic        r4_ready, r4_valid, r4_mem_req, r4_flush, r4_retire, r4_trap, r4_busy;
    logic [31:0] r4_inst;
    logic [1:0]  r4_type;
    logic [2:0]  r4_dtype;
    logic [3:0]  retire_cnt4;
`ifdef INST_SEQ_PERF_EN
    logic [15:0] mul_cnt, mem_stall_cnt;
    logic [3:0]  mul_cnt4, mem_stall_cnt4;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt = 0;
    int model_mul = 0;
    int model_stall = 0;

    inst_issue_seq #(
        .MUL_CYCLES(MUL_C), .SHREG_CYCLES(SHR_C), .FLUSH_CYCLES(FL_C), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .inst_valid_i(inst_valid), .inst_in_i(inst_in),
        .inst_ready_o(inst_ready), .exec_valid_o(exec_valid), .exec_inst_o(exec_inst),
        .exec_type_o(exec_type), .exec_dtype_o(exec_dtype), .mem_req_o(mem_req),
        .mem_ack_i(mem_ack), .flush_o(flush), .retire_o(retire), .undef_trap_o(undef_trap),
        .busy_o(busy),
`ifdef INST_SEQ_PERF_EN
        .mul_cnt_o(mul_cnt), .mem_stall_cnt_o(mem_stall_cnt),
`endif
        .retire_cnt_o(retire_cnt)
    );

    inst_issue_seq #(
        .MUL_CYCLES(MUL_C), .SHREG_CYCLES(SHR_C), .FLUSH_CYCLES(FL_C), .CNT_W(4)
    ) dut4 (
        .clk_i(clk), .rst_i(rst), .inst_valid_i(inst_valid), .inst_in_i(inst_in),
        .inst_ready_o(r4_ready), .exec_valid_o(r4_valid), .exec_inst_o(r4_inst),
        .exec_type_o(r4_type), .exec_dtype_o(r4_dtype), .mem_req_o(r4_mem_req),
        .mem_ack_i(mem_ack), .flush_o(r4_flush), .retire_o(r4_retire),
        .undef_trap_o(r4_trap), .busy_o(r4_busy),
`ifdef INST_SEQ_PERF_EN
        .mul_cnt_o(mul_cnt4), .mem_stall_cnt_o(mem_stall_cnt4),
`endif
        .retire_cnt_o(retire_cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the classification rules.
    function automatic void ref_class(input logic [31:0] w, output int cls, output int dt);
        int op;
        op  = int'(w[27:26]);
        cls = (op == 0) ? 1 : (op == 1) ? 2 : (op == 2) ? 3 : 0;
        dt  = 0;
        if (cls == 1) begin
            if (w[25])                                dt = 1;
            else if (!w[4])                           dt = 2;
            else if (!w[7])                           dt = 3;
            else if (!w[24] && w[7:4] == 4'b1001)     dt = 4;
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".ctl"}, {25'd0, inst_ready, exec_valid, busy, mem_req, flush, retire,
                            undef_trap}, 32'h40);
        chk({tag, ".inst"}, exec_inst, 32'h0);
        chk({tag, ".type"}, {27'd0, exec_type, exec_dtype}, 32'h0);
        chk({tag, ".cnt"}, {16'd0, retire_cnt}, 32'(model_cnt % 65536));
        chk({tag, ".cnt4"}, {28'd0, retire_cnt4}, 32'(model_cnt % 16));
`ifdef INST_SEQ_PERF_EN
        chk({tag, ".mulcnt"}, {16'd0, mul_cnt}, 32'(model_mul % 65536));
        chk({tag, ".stallcnt"}, {16'd0, mem_stall_cnt}, 32'(model_stall % 65536));
`endif
    endtask

    task automatic run_inst(input logic [31:0] w, input int ack_delay);
        int cls, dt, len;
        bit trap;
        logic [6:0] exp_ctl;
        ref_class(w, cls, dt);
        trap = (cls == 0) || (cls == 1 && dt == 0);
        if (trap)           len = 1;
        else if (cls == 1)  len = (dt == 3) ? SHR_C : (dt == 4) ? MUL_C : 1;
        else if (cls == 2)  len = ack_delay + 1;
        else                len = FL_C;

        @(negedge clk);
        inst_valid = 1'b1;
        inst_in    = w;
        mem_ack    = 1'($urandom);
        #1;
        check_idle("idle");
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            inst_in    = $urandom;
            inst_valid = (i == len - 1) ? 1'b0 : 1'($urandom);
            mem_ack    = (cls == 2) ? (i == ack_delay) : 1'($urandom);
            #1;
            exp_ctl = {1'b0, 1'b1, 1'b1, (cls == 2), (cls == 3),
                       (!trap && i == len - 1), trap};
            chk("exec.ctl", {25'd0, inst_ready, exec_valid, busy, mem_req, flush, retire,
                             undef_trap}, {25'd0, exp_ctl});
            chk("exec.inst", exec_inst, w);
            chk("exec.type", {27'd0, exec_type, exec_dtype}, 32'((cls << 3) | dt));
            chk("exec.cnt", {16'd0, retire_cnt}, 32'(model_cnt % 65536));
        end
        if (!trap) model_cnt++;
        if (cls == 1 && dt == 4) model_mul++;
        if (cls == 2) model_stall += ack_delay;
    endtask

    initial begin
        logic [31:0] w;
        int          ack_delay;

        @(negedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        run_inst(32'hE3A00001, 0);
        run_inst(32'hE0000291, 0);
        run_inst(32'hE5901000, 4);
        run_inst(32'hEA000000, 0);
        run_inst(32'hEE000000, 0);
        run_inst(32'hE1A00211, 0);
        for (int k = 0; k < 16; k++) run_inst(32'hE3A00001, 0);

        for (int k = 0; k < 60; k++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                w[27:24] = 4'b0000;
                w[7:4]   = 4'b1001;
            end
            ack_delay = $urandom_range(0, 5);
            run_inst(w, ack_delay);
        end

        // Asynchronous reset in the middle of a memory wait.
        @(negedge clk);
        inst_valid = 1'b1;
        inst_in    = 32'hE5901000;
        mem_ack    = 1'b0;
        @(negedge clk);
        inst_valid = 1'b0;
        #1;
        chk("memwait.req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_cnt   = 0;
        model_mul   = 0;
        model_stall = 0;
        check_idle("midreset");
        @(negedge clk);
        rst = 1'b0;

        run_inst(32'hE5901000, 2);
        run_inst(32'hE0000291, 0);
        @(negedge clk);
        #1;
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
